// File: rtl/ycc422_pair_sched_if.sv
// Timing bundle between the raw sync stream and the 4:2:2 pairing scheduler.
// YCC422_ERR_CNT_EN adds the err_cnt_out unlock counter to the bundle.
interface ycc422_pair_sched_if #(
   parameter int PIX_W  = 12,
   parameter int LINE_W = 12
);
   logic              hsync_in;
   logic              vsync_in;
   logic              de_in;
   logic              hsync_out;
   logic              vsync_out;
   logic              de_out;
   logic              pair_start_out;
   logic              chroma_sel_out;
   logic              valid_out;
   logic              frame_start_out;
   logic              locked_out;
   logic              odd_line_out;
   logic [PIX_W-1:0]  h_active_out;
   logic [LINE_W-1:0] v_active_out;
`ifdef YCC422_ERR_CNT_EN
   logic [7:0]        err_cnt_out;

   modport slave (
      input  hsync_in, vsync_in, de_in,
      output hsync_out, vsync_out, de_out, pair_start_out, chroma_sel_out,
             valid_out, frame_start_out, locked_out, odd_line_out,
             h_active_out, v_active_out, err_cnt_out
   );

   modport master (
      output hsync_in, vsync_in, de_in,
      input  hsync_out, vsync_out, de_out, pair_start_out, chroma_sel_out,
             valid_out, frame_start_out, locked_out, odd_line_out,
             h_active_out, v_active_out, err_cnt_out
   );
`else
   modport slave (
      input  hsync_in, vsync_in, de_in,
      output hsync_out, vsync_out, de_out, pair_start_out, chroma_sel_out,
             valid_out, frame_start_out, locked_out, odd_line_out,
             h_active_out, v_active_out
   );

   modport master (
      output hsync_in, vsync_in, de_in,
      input  hsync_out, vsync_out, de_out, pair_start_out, chroma_sel_out,
             valid_out, frame_start_out, locked_out, odd_line_out,
             h_active_out, v_active_out
   );
`endif
endinterface

// File: rtl/ycc422_pair_sched.sv
// Pair/chroma strobe generator and format lock for the 4:4:4 -> 4:2:2 path.
// Define YCC422_ERR_CNT_EN to add a saturating count of lock losses (err_cnt_out).
module ycc422_pair_sched #(
   parameter int PIX_W       = 12,
   parameter int LINE_W      = 12,
   parameter int LOCK_FRAMES = 2,
   parameter int VS_POL      = 1
) (
   input  logic                clk,
   input  logic                rst,
   ycc422_pair_sched_if.slave  vif
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MEASURE,
      ST_LOCKED
   } state_t;

   localparam logic [PIX_W-1:0]  PIX_MAX   = '1;
   localparam logic [LINE_W-1:0] LINE_MAX  = '1;
   localparam logic              VS_ACT    = (VS_POL != 0);
   localparam logic [3:0]        LOCK_LAST = 4'(LOCK_FRAMES - 1);

   state_t            state_q, state_d;
   logic              hsync_q, hsync_d;
   logic              vsync_q, vsync_d;
   logic              de_q, de_d;
   logic              pair_start_q, pair_start_d;
   logic              chroma_sel_q, chroma_sel_d;
   logic              valid_q, valid_d;
   logic              frame_start_q, frame_start_d;
   logic              locked_q, locked_d;
   logic              odd_line_q, odd_line_d;
   logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
   logic [PIX_W-1:0]  line_len_q, line_len_d;
   logic [LINE_W-1:0] line_cnt_q, line_cnt_d;
   logic [PIX_W-1:0]  ref_len_q, ref_len_d;
   logic [LINE_W-1:0] ref_cnt_q, ref_cnt_d;
   logic [3:0]        match_q, match_d;
   logic [PIX_W-1:0]  h_active_q, h_active_d;
   logic [LINE_W-1:0] v_active_q, v_active_d;

   logic              de_rise, de_fall, vs_edge;
   logic [PIX_W-1:0]  pix_idx;
   logic [PIX_W-1:0]  eff_len;
   logic [LINE_W-1:0] eff_cnt;
   logic              frame_ok, frame_same;

   // Line/frame measurement; eff_* is the frame pair after this cycle's line is counted.
   always_comb begin
      de_rise = vif.de_in & ~de_q;
      de_fall = ~vif.de_in & de_q;
      vs_edge = (vif.vsync_in == VS_ACT) && (vsync_q != VS_ACT);

      hsync_d = vif.hsync_in;
      vsync_d = vif.vsync_in;
      de_d    = vif.de_in;

      pix_idx   = de_rise ? '0 : pix_cnt_q;
      pix_cnt_d = pix_cnt_q;
      if (vif.de_in) begin
         pix_cnt_d = (pix_idx == PIX_MAX) ? PIX_MAX : pix_idx + PIX_W'(1);
      end

      pair_start_d  = vif.de_in & ~pix_idx[0];
      chroma_sel_d  = vif.de_in & pix_idx[0];
      frame_start_d = vs_edge;

      line_len_d = line_len_q;
      odd_line_d = odd_line_q;
      line_cnt_d = line_cnt_q;
      if (de_fall) begin
         line_len_d = pix_cnt_q;
         odd_line_d = pix_cnt_q[0];
         if (line_cnt_q != LINE_MAX) begin
            line_cnt_d = line_cnt_q + LINE_W'(1);
         end
      end
      eff_len = line_len_d;
      eff_cnt = line_cnt_d;
      if (vs_edge) begin
         line_cnt_d = '0;
      end

      frame_ok   = (eff_cnt != '0) && (eff_len != '0) &&
                   (eff_cnt != LINE_MAX) && (eff_len != PIX_MAX);
      frame_same = (eff_len == ref_len_q) && (eff_cnt == ref_cnt_q);
   end

   // Lock FSM next-state and lock-related outputs.
   always_comb begin
      state_d    = state_q;
      ref_len_d  = ref_len_q;
      ref_cnt_d  = ref_cnt_q;
      match_d    = match_q;
      locked_d   = locked_q;
      h_active_d = h_active_q;
      v_active_d = v_active_q;

      case (state_q)
         ST_IDLE: begin
            if (vs_edge) begin
               ref_len_d = eff_len;
               ref_cnt_d = eff_cnt;
               match_d   = '0;
               state_d   = ST_MEASURE;
            end
         end
         ST_MEASURE: begin
            if (vs_edge) begin
               if (frame_ok && frame_same) begin
                  match_d = match_q + 4'd1;
                  if (match_d >= LOCK_LAST) begin
                     state_d    = ST_LOCKED;
                     locked_d   = 1'b1;
                     h_active_d = ref_len_q;
                     v_active_d = ref_cnt_q;
                  end
               end else begin
                  ref_len_d = eff_len;
                  ref_cnt_d = eff_cnt;
                  match_d   = '0;
               end
            end
         end
         ST_LOCKED: begin
            if ((de_fall && (eff_len != h_active_q)) ||
                (vs_edge && (eff_cnt != v_active_q))) begin
               state_d    = ST_MEASURE;
               locked_d   = 1'b0;
               h_active_d = '0;
               v_active_d = '0;
               match_d    = '0;
               ref_len_d  = eff_len;
               ref_cnt_d  = eff_cnt;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      valid_d = vif.de_in & locked_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         hsync_q       <= 1'b0;
         vsync_q       <= 1'b0;
         de_q          <= 1'b0;
         pair_start_q  <= 1'b0;
         chroma_sel_q  <= 1'b0;
         valid_q       <= 1'b0;
         frame_start_q <= 1'b0;
         locked_q      <= 1'b0;
         odd_line_q    <= 1'b0;
         pix_cnt_q     <= '0;
         line_len_q    <= '0;
         line_cnt_q    <= '0;
         ref_len_q     <= '0;
         ref_cnt_q     <= '0;
         match_q       <= '0;
         h_active_q    <= '0;
         v_active_q    <= '0;
      end else begin
         state_q       <= state_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
         pair_start_q  <= pair_start_d;
         chroma_sel_q  <= chroma_sel_d;
         valid_q       <= valid_d;
         frame_start_q <= frame_start_d;
         locked_q      <= locked_d;
         odd_line_q    <= odd_line_d;
         pix_cnt_q     <= pix_cnt_d;
         line_len_q    <= line_len_d;
         line_cnt_q    <= line_cnt_d;
         ref_len_q     <= ref_len_d;
         ref_cnt_q     <= ref_cnt_d;
         match_q       <= match_d;
         h_active_q    <= h_active_d;
         v_active_q    <= v_active_d;
      end
   end

`ifdef YCC422_ERR_CNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if ((state_q == ST_LOCKED) && (state_d == ST_MEASURE) && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_q <= 8'd0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign vif.err_cnt_out = err_cnt_q;
`endif

   assign vif.hsync_out       = hsync_q;
   assign vif.vsync_out       = vsync_q;
   assign vif.de_out          = de_q;
   assign vif.pair_start_out  = pair_start_q;
   assign vif.chroma_sel_out  = chroma_sel_q;
   assign vif.valid_out       = valid_q;
   assign vif.frame_start_out = frame_start_q;
   assign vif.locked_out      = locked_q;
   assign vif.odd_line_out    = odd_line_q;
   assign vif.h_active_out    = h_active_q;
   assign vif.v_active_out    = v_active_q;

endmodule

// File: tb/tb_ycc422_pair_sched.sv
// Directed bench for ycc422_pair_sched: strobe table, lock/unlock sequences,
// and a second instance with active-low vsync that must lock on the same cycles.
module tb_ycc422_pair_sched;

   logic clk;
   logic rst;

   ycc422_pair_sched_if #(.PIX_W(12), .LINE_W(12)) a_if ();
   ycc422_pair_sched_if #(.PIX_W(12), .LINE_W(12)) b_if ();

   ycc422_pair_sched #(.PIX_W(12), .LINE_W(12), .LOCK_FRAMES(2), .VS_POL(1)) dut_a (
      .clk (clk),
      .rst (rst),
      .vif (a_if.slave)
   );

   ycc422_pair_sched #(.PIX_W(12), .LINE_W(12), .LOCK_FRAMES(2), .VS_POL(0)) dut_b (
      .clk (clk),
      .rst (rst),
      .vif (b_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic de;
      logic vs;
      logic hs;
      logic pair;
      logic chroma;
      logic odd;
   } vec_t;

   vec_t tbl [20];
   int   checks = 0;
   int   errors = 0;
   logic exp_lock = 1'b0;

   function automatic vec_t mk(input logic de, input logic vs, input logic hs,
                               input logic pair, input logic chroma, input logic odd);
      vec_t v;
      v.de = de; v.vs = vs; v.hs = hs; v.pair = pair; v.chroma = chroma; v.odd = odd;
      return v;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of raw inputs; on return the outputs reflect them.
   task automatic cyc(input logic de, input logic vs, input logic hs);
      a_if.de_in    = de;
      a_if.vsync_in = vs;
      a_if.hsync_in = hs;
      b_if.de_in    = de;
      b_if.vsync_in = ~vs;
      b_if.hsync_in = hs;
      @(negedge clk);
   endtask

   task automatic line(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(1'b1, 1'b0, 1'b0);
         chk("valid_line", a_if.valid_out, exp_lock);
      end
      cyc(1'b0, 1'b0, 1'b1);
      chk("valid_gap", a_if.valid_out, 0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
   endtask

   task automatic frame4();
      for (int i = 0; i < 4; i++) line(8);
   endtask

   task automatic vs_pulse(input logic exp_lk, input string tag);
      cyc(1'b0, 1'b1, 1'b0);
      chk({tag, "_fs"}, a_if.frame_start_out, 1);
      chk({tag, "_lock"}, a_if.locked_out, exp_lk);
      chk({tag, "_fs_b"}, b_if.frame_start_out, 1);
      chk({tag, "_lock_b"}, b_if.locked_out, exp_lk);
      exp_lock = exp_lk;
      cyc(1'b0, 1'b1, 1'b0);
      chk({tag, "_fs_end"}, a_if.frame_start_out, 0);
      cyc(1'b0, 1'b0, 1'b0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_hs"}, a_if.hsync_out, 0);
      chk({tag, "_vs"}, a_if.vsync_out, 0);
      chk({tag, "_de"}, a_if.de_out, 0);
      chk({tag, "_pair"}, a_if.pair_start_out, 0);
      chk({tag, "_chroma"}, a_if.chroma_sel_out, 0);
      chk({tag, "_valid"}, a_if.valid_out, 0);
      chk({tag, "_fs"}, a_if.frame_start_out, 0);
      chk({tag, "_lock"}, a_if.locked_out, 0);
      chk({tag, "_odd"}, a_if.odd_line_out, 0);
      chk({tag, "_h"}, a_if.h_active_out, 0);
      chk({tag, "_v"}, a_if.v_active_out, 0);
      chk({tag, "_vs_b"}, b_if.vsync_out, 0);
`ifdef YCC422_ERR_CNT_EN
      chk({tag, "_err"}, a_if.err_cnt_out, 0);
`endif
   endtask

   initial begin
      // 7 px line, 3 gap cycles (hsync in the first), 8 px line, 2 gap cycles.
      tbl[0]  = mk(1, 0, 0, 1, 0, 0);
      tbl[1]  = mk(1, 0, 0, 0, 1, 0);
      tbl[2]  = mk(1, 0, 0, 1, 0, 0);
      tbl[3]  = mk(1, 0, 0, 0, 1, 0);
      tbl[4]  = mk(1, 0, 0, 1, 0, 0);
      tbl[5]  = mk(1, 0, 0, 0, 1, 0);
      tbl[6]  = mk(1, 0, 0, 1, 0, 0);
      tbl[7]  = mk(0, 0, 1, 0, 0, 1);
      tbl[8]  = mk(0, 0, 0, 0, 0, 1);
      tbl[9]  = mk(0, 0, 0, 0, 0, 1);
      tbl[10] = mk(1, 0, 0, 1, 0, 1);
      tbl[11] = mk(1, 0, 0, 0, 1, 1);
      tbl[12] = mk(1, 0, 0, 1, 0, 1);
      tbl[13] = mk(1, 0, 0, 0, 1, 1);
      tbl[14] = mk(1, 0, 0, 1, 0, 1);
      tbl[15] = mk(1, 0, 0, 0, 1, 1);
      tbl[16] = mk(1, 0, 0, 1, 0, 1);
      tbl[17] = mk(1, 0, 0, 0, 1, 1);
      tbl[18] = mk(0, 0, 0, 0, 0, 0);
      tbl[19] = mk(0, 0, 0, 0, 0, 0);

      // Reset held with busy inputs: every output must stay 0.
      rst = 1'b1;
      a_if.de_in = 1'b1; a_if.vsync_in = 1'b1; a_if.hsync_in = 1'b1;
      b_if.de_in = 1'b1; b_if.vsync_in = 1'b0; b_if.hsync_in = 1'b1;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      cyc(1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 20; i++) begin
         cyc(tbl[i].de, tbl[i].vs, tbl[i].hs);
         chk($sformatf("tbl%0d_pair", i), a_if.pair_start_out, tbl[i].pair);
         chk($sformatf("tbl%0d_chroma", i), a_if.chroma_sel_out, tbl[i].chroma);
         chk($sformatf("tbl%0d_odd", i), a_if.odd_line_out, tbl[i].odd);
         chk($sformatf("tbl%0d_de", i), a_if.de_out, tbl[i].de);
         chk($sformatf("tbl%0d_hs", i), a_if.hsync_out, tbl[i].hs);
         chk($sformatf("tbl%0d_valid", i), a_if.valid_out, 0);
      end

      // Reset asserted mid-line: outputs drop without waiting for a clock.
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1 chk("midrst_de", a_if.de_out, 0);
      chk("midrst_pair", a_if.pair_start_out, 0);
      chk("midrst_vs_b", b_if.vsync_out, 0);
      @(negedge clk);
      rst = 1'b0;
      cyc(1'b1, 1'b0, 1'b0);
      chk("post_rst_pair", a_if.pair_start_out, 1);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 0);
      cyc(1'b0, 1'b0, 0);

      // Lock after the third vsync edge.
      vs_pulse(1'b0, "e1");
      frame4();
      vs_pulse(1'b0, "e2");
      chk("vs_out_b", b_if.vsync_out, 1);
      frame4();
      chk("pre_lock", a_if.locked_out, 0);
      vs_pulse(1'b1, "e3");
      chk("h_lock", a_if.h_active_out, 8);
      chk("v_lock", a_if.v_active_out, 4);
      chk("h_lock_b", b_if.h_active_out, 8);
      frame4();
      vs_pulse(1'b1, "e4");

      // A 6 px line drops lock right at the de fall.
      line(8);
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, 1'b0, 1'b0);
         chk("valid_short", a_if.valid_out, 1);
      end
      cyc(1'b0, 1'b0, 1'b1);
      chk("short_lock", a_if.locked_out, 0);
      chk("short_h", a_if.h_active_out, 0);
      chk("short_v", a_if.v_active_out, 0);
      chk("short_odd", a_if.odd_line_out, 0);
`ifdef YCC422_ERR_CNT_EN
      chk("short_err", a_if.err_cnt_out, 1);
`endif
      exp_lock = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      line(8);
      line(8);
      vs_pulse(1'b0, "e5");
      frame4();
      vs_pulse(1'b1, "e6");
      chk("relock_h", a_if.h_active_out, 8);
      chk("relock_v", a_if.v_active_out, 4);

      // Five lines in a locked frame: unlock at the vsync edge.
      for (int i = 0; i < 5; i++) line(8);
      vs_pulse(1'b0, "e7");
      chk("tall_v", a_if.v_active_out, 0);
`ifdef YCC422_ERR_CNT_EN
      chk("tall_err", a_if.err_cnt_out, 2);
`endif
      frame4();
      vs_pulse(1'b0, "e8");
      frame4();
      vs_pulse(1'b1, "e9");

      // De fall coincides with vsync edge: the last line still counts.
      for (int i = 0; i < 3; i++) line(8);
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      chk("sim_fs", a_if.frame_start_out, 1);
      chk("sim_lock", a_if.locked_out, 1);
      chk("sim_lock_b", b_if.locked_out, 1);
      chk("sim_v", a_if.v_active_out, 4);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      frame4();
      vs_pulse(1'b1, "e11");
      chk("final_h", a_if.h_active_out, 8);
`ifdef YCC422_ERR_CNT_EN
      chk("final_err", a_if.err_cnt_out, 2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
